// File: rtl/deser16_if.sv
// Serial-in / parallel-out bundle for deser16: serial bit stream in, word handshake out.
// The master is the stream source and word consumer; the slave is the deserialiser.
interface deser16_if;
  logic        sdi;
  logic        sen;
  logic        sync;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        ovr;
  logic        perr;

  modport master (
    output sdi, sen, sync, out_ready,
    input  out, out_valid, ovr, perr
  );

  modport slave (
    input  sdi, sen, sync, out_ready,
    output out, out_valid, ovr, perr
  );
endinterface

// File: rtl/deser16.sv
// 16-bit MSB-first serial deserialiser with a one-word output register and sticky overrun.
// Define DESER16_PARITY_EN to expect a trailing even-parity bit and report it on perr.
module deser16 (
  input logic   clk,
  input logic   nreset,
  deser16_if.slave bus
);

`ifdef DESER16_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] sreg_q, sreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        done;
  logic [15:0] word;
`ifdef DESER16_PARITY_EN
  logic        perr_q, perr_d;
  logic        word_perr;
`endif

  // Bits enter at the LSB and shift up, so the first (SYNC) bit lands in bit 15 after 16 bits.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    word    = sreg_q;
`ifdef DESER16_PARITY_EN
    word_perr = 1'b0;
`endif
    if (bus.sen) begin
      if (bus.sync) begin
        sreg_d  = {15'd0, bus.sdi};
        cnt_d   = 5'd1;
        state_d = StShift;
      end else begin
        case (state_q)
          StIdle: ;
          StShift: begin
            sreg_d = {sreg_q[14:0], bus.sdi};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
`ifdef DESER16_PARITY_EN
              state_d = StPar;
`else
              done    = 1'b1;
              word    = sreg_d;
              cnt_d   = 5'd0;
              state_d = StIdle;
`endif
            end
          end
`ifdef DESER16_PARITY_EN
          StPar: begin
            done      = 1'b1;
            word      = sreg_q;
            word_perr = ^{sreg_q, bus.sdi};
            cnt_d     = 5'd0;
            state_d   = StIdle;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // A completed word takes the output slot only if it is empty or being emptied this cycle.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef DESER16_PARITY_EN
    perr_d  = perr_q;
`endif
    if (done) begin
      if (!valid_q || bus.out_ready) begin
        out_d   = word;
        valid_d = 1'b1;
`ifdef DESER16_PARITY_EN
        perr_d  = word_perr;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StIdle;
      sreg_q  <= 16'h0000;
      cnt_q   <= 5'd0;
      out_q   <= 16'h0000;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DESER16_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef DESER16_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.ovr       = ovr_q;
`ifdef DESER16_PARITY_EN
  assign bus.perr      = perr_q;
`else
  assign bus.perr      = 1'b0;
`endif

endmodule

// File: tb/tb_deser16.sv
// Randomised scoreboard bench for deser16; stimulus pushes expected words, a monitor pops them.
// Honours DESER16_PARITY_EN the same way the design does.
module tb_deser16;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  deser16_if bus ();

  deser16 dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

`ifdef DESER16_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [16:0] sbq[$];     // {perr, word} expected at each accepted handshake
  logic [16:0] mon_item;
  bit          exp_ovr;
  bit          in_idle;
  int          ready_mode; // 0: always ready, 1: random, 2: never ready

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit pick_rdy(input int forced);
    if (forced >= 0) return forced[0];
    case (ready_mode)
      0:       return 1'b1;
      1:       return bit'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // Spec-level output slot: a word is dropped only if one is still pending and not taken now.
  function automatic void model_done(input logic [15:0] w, input bit p, input bit rdy);
    logic pe;
    pe = (NBITS == 17) ? ^{w, p} : 1'b0;
    if (sbq.size() != 0 && !rdy) exp_ovr = 1'b1;
    else sbq.push_back({pe, w});
  endfunction

  task automatic cyc(input bit en, input bit sy, input bit di, input bit rdy);
    bus.sen       = en;
    bus.sync      = sy;
    bus.sdi       = di;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input bit p, input int nsend,
                           input int gap_mode, input int last_rdy);
    bit b;
    bit rdy;
    bit last;
    int gaps;
    for (int i = 0; i < nsend; i++) begin
      if (i > 0) begin
        gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 3)) : 0);
        for (int g = 0; g < gaps; g++)
          cyc(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), pick_rdy(-1));
      end
      b    = (i < 16) ? w[15 - i] : p;
      last = (nsend == NBITS) && (i == NBITS - 1);
      rdy  = pick_rdy(last ? last_rdy : -1);
      if (last) model_done(w, p, rdy);
      cyc(1'b1, (i == 0), b, rdy);
    end
    in_idle = (nsend == NBITS);
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    nreset = 1'b1;
    sbq.delete();
    exp_ovr = 1'b0;
    in_idle = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sbq.size() != 0; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_out"}, 32'(bus.out), 32'h0);
    check({name, "_valid"}, 32'(bus.out_valid), 32'h0);
    check({name, "_ovr"}, 32'(bus.ovr), 32'h0);
    check({name, "_perr"}, 32'(bus.perr), 32'h0);
  endtask

  always @(negedge clk) begin
    if (nreset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h expected no word", bus.out);
      end else begin
        mon_item = sbq.pop_front();
        check("word", 32'(bus.out), 32'(mon_item[15:0]));
        check("perr", 32'(bus.perr), 32'(mon_item[16]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    bit          p;
    int          nsend;

    nreset        = 1'b0;
    bus.sen       = 1'b0;
    bus.sync      = 1'b0;
    bus.sdi       = 1'b0;
    bus.out_ready = 1'b0;
    ready_mode    = 0;
    exp_ovr       = 1'b0;
    in_idle       = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_zero("reset");
    nreset = 1'b1;

    // Basic: one-cycle latency and one-cycle valid pulse with consumer always ready.
    send_word(16'hA5C3, ^16'hA5C3, NBITS, 0, -1);
    check("basic_valid", 32'(bus.out_valid), 32'h1);
    check("basic_out", 32'(bus.out), 32'hA5C3);
    check("basic_ovr", 32'(bus.ovr), 32'(exp_ovr));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_pulse", 32'(bus.out_valid), 32'h0);

    // SEN gaps on alternate cycles must not lose or duplicate bits.
    send_word(16'hA5C3, ^16'hA5C3, NBITS, 1, -1);
    check("gap_out", 32'(bus.out), 32'hA5C3);
    drain("gap_drain");

    // Back-to-back with consumer stalled: second word dropped, first held, overrun flagged.
    apply_reset();
    ready_mode = 2;
    send_word(16'h1234, ^16'h1234, NBITS, 0, -1);
    send_word(16'hFFFF, ^16'hFFFF, NBITS, 0, -1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_ovr", 32'(bus.ovr), 32'(exp_ovr));
    check("b2b_hold", 32'(bus.out), 32'h1234);
    check("b2b_valid", 32'(bus.out_valid), 32'h1);
    drain("b2b_drain");
    check("b2b_empty", 32'(bus.out_valid), 32'h0);

    // Handshake on the completion cycle replaces the word without a bubble.
    apply_reset();
    send_word(16'h1234, ^16'h1234, NBITS, 0, -1);
    send_word(16'hFFFF, ^16'hFFFF, NBITS, 0, 1);
    check("same_valid", 32'(bus.out_valid), 32'h1);
    check("same_out", 32'(bus.out), 32'hFFFF);
    check("same_ovr", 32'(bus.ovr), 32'(exp_ovr));
    drain("same_drain");

    // SYNC after 7 bits aborts the partial word.
    ready_mode = 0;
    send_word(16'hBEEF, 1'b0, 7, 0, -1);
    send_word(16'h0F0F, ^16'h0F0F, NBITS, 0, -1);
    drain("abort_drain");

    // Reset after 9 bits, with a word also pending, discards everything.
    ready_mode = 2;
    send_word(16'h2468, ^16'h2468, NBITS, 0, -1);
    send_word(16'h1357, 1'b0, 9, 0, -1);
    nreset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    nreset = 1'b1;
    sbq.delete();
    exp_ovr = 1'b0;
    in_idle = 1'b1;
    check_zero("midreset");
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("midreset_quiet", 32'(bus.out_valid), 32'h0);
    ready_mode = 0;

`ifdef DESER16_PARITY_EN
    send_word(16'h0001, 1'b1, NBITS, 0, -1);
    check("par_ok", 32'(bus.perr), 32'h0);
    send_word(16'h0001, 1'b0, NBITS, 0, -1);
    check("par_err", 32'(bus.perr), 32'h1);
    check("par_err_out", 32'(bus.out), 32'h0001);
    drain("par_drain");
`endif

    // Random words, gaps, idle junk, aborts and consumer back-pressure.
    apply_reset();
    ready_mode = 1;
    for (int n = 0; n < 60; n++) begin
      if (in_idle && ($urandom_range(0, 2) == 0)) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          cyc(1'b1, 1'b0, bit'($urandom_range(0, 1)), pick_rdy(-1));
      end
      w     = 16'($urandom);
      p     = bit'($urandom_range(0, 1));
      nsend = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NBITS - 1)) : NBITS;
      send_word(w, p, nsend, 2, -1);
    end
    ready_mode = 0;
    drain("rand_drain");
    check("rand_ovr", 32'(bus.ovr), 32'(exp_ovr));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
